volume_ramp: RTL and testbench

- Per-channel digital volume stage directly downstream of the moving-average smoothing stage; consumes its 24-bit signed sample stream over a valid/ready handshake.
- Multiplies each sample by an 8-bit unsigned gain (unity = 128), saturates to 24 bits and forwards the result to the output mixer/serializer.
- Gain changes and mute are applied as a per-sample linear ramp to avoid zipper noise.
- Two-stage pipeline with full backpressure support.

---
 rtl/volume_ramp.sv | 181 ++++++++++++++++++
 tb/tb_volume_ramp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/volume_ramp.sv
// Per-channel volume stage: 24-bit signed sample x 8-bit gain (unity 128), saturated,
// with zipper-free linear gain ramps. Optional clip counter under VOLUME_RAMP_CLIP_CNT_EN.
module volume_ramp #(
   parameter int unsigned RAMP_STEP  = 16,
   parameter int unsigned GAIN_RESET = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [23:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_clip,
   input  logic [7:0]  gain_target,
   input  logic        mute,
   output logic        ramping,
`ifdef VOLUME_RAMP_CLIP_CNT_EN
   input  logic        clip_clr,
   output logic [15:0] clip_count,
`endif
   output logic [1:0]  dbg_state,
   output logic [7:0]  dbg_gain
);

   // Handshake: a word moves across an interface on a cycle where valid and ready are
   // both high; valid never waits on ready, and data is held stable while valid && !ready.

   typedef enum logic [1:0] {
      ST_STEADY = 2'd0,
      ST_RAMP   = 2'd1,
      ST_MUTED  = 2'd2
   } state_t;

   localparam logic [7:0]         STEP      = 8'(RAMP_STEP);
   localparam logic [7:0]         GAIN_INIT = 8'(GAIN_RESET);
   localparam logic signed [32:0] SAT_MAX   = 33'sd8388607;
   localparam logic signed [32:0] SAT_MIN   = -33'sd8388608;

   state_t             state;
   state_t             state_next;
   logic [7:0]         cur_gain;
   logic [7:0]         gain_next;
   logic [7:0]         gain_stepped;
   logic [7:0]         eff_target;
   logic [7:0]         diff_up;
   logic [7:0]         diff_dn;

   logic               accept;
   logic               s2_load;
   logic               s1_valid;
   logic signed [32:0] s1_product;
   logic signed [32:0] in_ext;
   logic signed [32:0] gain_ext;
   logic signed [32:0] mult;
   logic signed [32:0] shifted;
   logic [23:0]        sat_data;
   logic               sat_clip;

   assign eff_target = mute ? 8'd0 : gain_target;
   assign in_ready   = !s1_valid || !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign s2_load    = !out_valid || out_ready;

   // Bounded step toward the target; the final step lands exactly on it.
   assign diff_up = eff_target - cur_gain;
   assign diff_dn = cur_gain - eff_target;

   always_comb begin
      gain_stepped = cur_gain;
      if (cur_gain < eff_target) begin
         gain_stepped = cur_gain + ((diff_up < STEP) ? diff_up : STEP);
      end else if (cur_gain > eff_target) begin
         gain_stepped = cur_gain - ((diff_dn < STEP) ? diff_dn : STEP);
      end
   end

   // Gain state machine: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_STEADY;
         cur_gain <= GAIN_INIT;
         ramping  <= 1'b0;
      end else begin
         state    <= state_next;
         cur_gain <= gain_next;
         ramping  <= (state_next == ST_RAMP);
      end
   end

   // Gain state machine: next state; gain only moves on accepted samples
   always_comb begin
      state_next = state;
      gain_next  = cur_gain;
      case (state)
         ST_STEADY: begin
            if (cur_gain != eff_target) state_next = ST_RAMP;
         end
         ST_RAMP: begin
            if (accept) gain_next = gain_stepped;
            if (gain_next == eff_target) begin
               state_next = (eff_target == 8'd0 && mute) ? ST_MUTED : ST_STEADY;
            end
         end
         ST_MUTED: begin
            gain_next = 8'd0;
            if (!mute) state_next = (gain_target != 8'd0) ? ST_RAMP : ST_STEADY;
         end
         default: begin
            state_next = ST_STEADY;
         end
      endcase
   end

   // Gain state machine: outputs
   always_comb begin
      dbg_state = state;
      dbg_gain  = cur_gain;
   end

   // Stage 1: full-precision product using the gain in force before this cycle's update
   assign in_ext   = {{9{in_data[23]}}, in_data};
   assign gain_ext = {25'd0, cur_gain};
   assign mult     = in_ext * gain_ext;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_product <= '0;
      end else if (accept) begin
         s1_valid   <= 1'b1;
         s1_product <= mult;
      end else if (s2_load) begin
         s1_valid   <= 1'b0;
      end
   end

   // Stage 2: arithmetic shift floors toward -inf, then clamp to the 24-bit range
   assign shifted = s1_product >>> 7;

   always_comb begin
      sat_data = shifted[23:0];
      sat_clip = 1'b0;
      if (shifted > SAT_MAX) begin
         sat_data = 24'h7FFFFF;
         sat_clip = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sat_data = 24'h800000;
         sat_clip = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_clip  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= sat_data;
            out_clip <= sat_clip;
         end
      end
   end

`ifdef VOLUME_RAMP_CLIP_CNT_EN
   // Counts saturated words as they leave; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         clip_count <= '0;
      end else if (clip_clr) begin
         clip_count <= '0;
      end else if (out_valid && out_ready && out_clip && clip_count != 16'hFFFF) begin
         clip_count <= clip_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_volume_ramp.sv
// Directed bench for volume_ramp: scoreboard of hand-computed outputs plus
// spot checks of latency, ramp progress, backpressure, mute and reset.
module tb_volume_ramp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_clip;
   logic [7:0]  gain_target = 8'd128;
   logic        mute = 1'b0;
   logic        ramping;
   logic [1:0]  dbg_state;
   logic [7:0]  dbg_gain;
`ifdef VOLUME_RAMP_CLIP_CNT_EN
   logic        clip_clr = 1'b0;
   logic [15:0] clip_count;
`endif

   // Clock / reset
   always #5 clk = ~clk;

   volume_ramp #(.RAMP_STEP(16), .GAIN_RESET(128)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_clip    (out_clip),
      .gain_target (gain_target),
      .mute        (mute),
      .ramping     (ramping),
`ifdef VOLUME_RAMP_CLIP_CNT_EN
      .clip_clr    (clip_clr),
      .clip_count  (clip_count),
`endif
      .dbg_state   (dbg_state),
      .dbg_gain    (dbg_gain)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          ramp_acc = 0;
   logic        count_ramp = 1'b0;
   logic [24:0] exp_q[$];
   logic [24:0] mon_e;
   logic [23:0] held;
   logic [23:0] mute_tbl[9] = '{24'h100000, 24'h0E0000, 24'h0C0000, 24'h0A0000, 24'h080000,
                                24'h060000, 24'h040000, 24'h020000, 24'h000000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: a transfer happens at the next posedge when valid && ready at negedge
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_data", 32'(out_data), 32'(mon_e[23:0]));
            check("sb_clip", 32'(out_clip), 32'(mon_e[24]));
         end
      end
      if (!reset && count_ramp && in_valid && in_ready && ramping) ramp_acc++;
   end

   // Drivers: every task starts and ends 1 time unit after a rising edge
   task automatic send(input logic [23:0] d, input logic [24:0] e);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      @(posedge clk);
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_ramp(input string tag);
      @(posedge clk);
      #1;
      check(tag, 32'(ramping), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_clip", 32'(out_clip), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_ramping", 32'(ramping), 32'd0);
      check("rst_gain", 32'(dbg_gain), 32'd128);
      check("rst_state", 32'(dbg_state), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_ready", 32'(in_ready), 32'd1);

      // Unity gain and two-cycle latency
      send(24'h400000, {1'b0, 24'h400000});
      in_valid = 1'b0;
      check("unity_lat1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("unity_lat2", 32'(out_valid), 32'd1);
      check("unity_data", 32'(out_data), 32'h400000);
      check("unity_ramp", 32'(ramping), 32'd0);
      drain();

      // Ramp 128 -> 255 takes 8 samples (last step is 15)
      gain_target = 8'd255;
      wait_ramp("up255_start");
      repeat (8) send(24'h000000, 25'h0);
      drain();
      check("up255_gain", 32'(dbg_gain), 32'd255);
      check("up255_ramp", 32'(ramping), 32'd0);

      // Saturation at gain 255, plus floor of -1 * 255 / 128
      send(24'h7FFFFF, {1'b1, 24'h7FFFFF});
      send(24'h800000, {1'b1, 24'h800000});
      send(24'h200000, {1'b0, 24'h3FC000});
      send(24'hFFFFFF, {1'b0, 24'hFFFFFE});
      drain();
`ifdef VOLUME_RAMP_CLIP_CNT_EN
      check("clip_count2", 32'(clip_count), 32'd2);
`endif

      gain_target = 8'd128;
      wait_ramp("back128_start");
      repeat (8) send(24'h000000, 25'h0);
      drain();
      check("back128_gain", 32'(dbg_gain), 32'd128);

      // Ramp down 128 -> 64 in 4 updating samples
      gain_target = 8'd64;
      wait_ramp("down64_start");
      ramp_acc   = 0;
      count_ramp = 1'b1;
      send(24'h010000, {1'b0, 24'h010000});
      send(24'h010000, {1'b0, 24'h00E000});
      send(24'h010000, {1'b0, 24'h00C000});
      send(24'h010000, {1'b0, 24'h00A000});
      send(24'h010000, {1'b0, 24'h008000});
      send(24'h010000, {1'b0, 24'h008000});
      drain();
      count_ramp = 1'b0;
      check("down64_ramp_samples", 32'(ramp_acc), 32'd4);
      check("down64_gain", 32'(dbg_gain), 32'd64);
      check("down64_state", 32'(dbg_state), 32'd0);
      send(24'hFFFFFF, {1'b0, 24'hFFFFFF});
      drain();

      gain_target = 8'd128;
      wait_ramp("up128_start");
      repeat (4) send(24'h000000, 25'h0);
      drain();
      check("up128_gain", 32'(dbg_gain), 32'd128);

      // Backpressure: 20 back-to-back samples, downstream stalls for 5 cycles
      fork
         begin
            for (int i = 1; i <= 20; i++) send(24'(i), {1'b0, 24'(i)});
            in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            held = out_data;
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clk);
               check("stall_in_ready", 32'(in_ready), 32'd0);
               check("stall_hold", 32'(out_data), 32'(held));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Mute: 8 samples down to 0, then MUTED; release ramps back in 8
      mute = 1'b1;
      wait_ramp("mute_start");
      for (int k = 0; k < 9; k++) send(24'h100000, {1'b0, mute_tbl[k]});
      drain();
      check("muted_state", 32'(dbg_state), 32'd2);
      check("muted_gain", 32'(dbg_gain), 32'd0);
      check("muted_ramp", 32'(ramping), 32'd0);
      send(24'h100000, 25'h0);
      drain();
      mute = 1'b0;
      wait_ramp("unmute_start");
      for (int k = 0; k < 9; k++) send(24'h100000, {1'b0, mute_tbl[8 - k]});
      drain();
      check("unmute_gain", 32'(dbg_gain), 32'd128);
      check("unmute_state", 32'(dbg_state), 32'd0);

      // Reset in the middle of a ramp with data in flight
      gain_target = 8'd64;
      wait_ramp("rr_start");
      send(24'h010000, {1'b0, 24'h010000});
      send(24'h010000, {1'b0, 24'h00E000});
      send(24'h010000, {1'b0, 24'h00C000});
      check("rr_pre_valid", 32'(out_valid), 32'd1);
      check("rr_pre_ramp", 32'(ramping), 32'd1);
      reset       = 1'b1;
      in_valid    = 1'b0;
      gain_target = 8'd128;
      @(posedge clk);
      #1;
      exp_q.delete();
      check("rr_valid", 32'(out_valid), 32'd0);
      check("rr_ramp", 32'(ramping), 32'd0);
      check("rr_gain", 32'(dbg_gain), 32'd128);
      check("rr_state", 32'(dbg_state), 32'd0);
`ifdef VOLUME_RAMP_CLIP_CNT_EN
      check("rr_clip_count", 32'(clip_count), 32'd0);
`endif
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rr_after_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
